// File: rtl/queue_arb_ctrl.sv
// Two-producer round-robin arbiter in front of an external queue, plus a
// registered valid/ready consumer stage fed from the queue head.
module queue_arb_ctrl #(
    parameter  int M_WIDTH  = 8,
    parameter  int N_WIDTH  = 8,
    parameter  int Q_LENGTH = 16,
    localparam int DW       = M_WIDTH + N_WIDTH,
    localparam int CW       = $clog2(Q_LENGTH)
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               req0,
    input  logic               req1,
    input  logic [DW-1:0]      data0,
    input  logic [DW-1:0]      data1,
    output logic               gnt0,
    output logic               gnt1,
    input  logic               q_full,
    input  logic               q_empty,
    input  logic [DW-1:0]      q_dout,
    output logic               q_wr,
    output logic               q_rd,
    output logic [M_WIDTH-1:0] q_m_din,
    output logic [N_WIDTH-1:0] q_n_din,
    output logic               q_clr,
    input  logic               flush,
    output logic               cons_vld,
    output logic [DW-1:0]      cons_data,
    input  logic               cons_rdy,
    output logic [CW-1:0]      count
);

    localparam logic [CW-1:0] CNT_MAX = CW'(Q_LENGTH - 1);

    logic          last_q,  last_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovld_q,  ovld_d;
    logic [DW-1:0] odata_q, odata_d;

    logic          grant_ok;
    logic          gnt0_w;
    logic          gnt1_w;
    logic          wr_w;
    logic          rd_w;
    logic [DW-1:0] sel_data;

    // last=1 favours producer 0; the grant gating on clr keeps strobes quiet in reset.
    always_comb begin
        grant_ok = clr & ~q_full & ~flush;
        gnt0_w   = grant_ok & req0 & (last_q | ~req1);
        gnt1_w   = grant_ok & req1 & (~last_q | ~req0);
        wr_w     = gnt0_w | gnt1_w;
        rd_w     = clr & ~q_empty & ~flush & (~ovld_q | cons_rdy);
        sel_data = gnt0_w ? data0 : (gnt1_w ? data1 : '0);
    end

    assign gnt0      = gnt0_w;
    assign gnt1      = gnt1_w;
    assign q_wr      = wr_w;
    assign q_rd      = rd_w;
    assign q_m_din   = sel_data[DW-1:N_WIDTH];
    assign q_n_din   = sel_data[N_WIDTH-1:0];
    assign q_clr     = clr & ~flush;
    assign cons_vld  = ovld_q;
    assign cons_data = odata_q;
    assign count     = count_q;

    always_comb begin
        last_d  = last_q;
        count_d = count_q;
        ovld_d  = ovld_q;
        odata_d = odata_q;
        if (flush) begin
            last_d  = 1'b1;
            count_d = '0;
            ovld_d  = 1'b0;
        end else begin
            if (gnt0_w) begin
                last_d = 1'b0;
            end else if (gnt1_w) begin
                last_d = 1'b1;
            end
            // Saturating bounds make the counter immune to a misbehaving queue.
            if (wr_w && !rd_w && count_q != CNT_MAX) begin
                count_d = count_q + 1'b1;
            end else if (rd_w && !wr_w && count_q != '0) begin
                count_d = count_q - 1'b1;
            end
            if (rd_w) begin
                ovld_d  = 1'b1;
                odata_d = q_dout;
            end else if (ovld_q && cons_rdy) begin
                ovld_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            last_q  <= 1'b1;
            count_q <= '0;
            ovld_q  <= 1'b0;
            odata_q <= '0;
        end else begin
            last_q  <= last_d;
            count_q <= count_d;
            ovld_q  <= ovld_d;
            odata_q <= odata_d;
        end
    end

endmodule

// File: tb/tb_queue_arb_ctrl.sv
// Bench for queue_arb_ctrl: models the external queue and the expected
// arbiter/consumer behaviour, with table vectors, corner sequences and random traffic.
module tb_queue_arb_ctrl;

    localparam int MW = 8;
    localparam int NW = 8;
    localparam int QL = 16;
    localparam int DW = MW + NW;
    localparam int CW = $clog2(QL);

    logic          clk;
    logic          clr;
    logic          req0, req1;
    logic [DW-1:0] data0, data1;
    logic          gnt0, gnt1;
    logic          qFull, qEmpty;
    logic [DW-1:0] qDout;
    logic          qWr, qRd;
    logic [MW-1:0] qMDin;
    logic [NW-1:0] qNDin;
    logic          qClr;
    logic          flush;
    logic          consVld;
    logic [DW-1:0] consData;
    logic          consRdy;
    logic [CW-1:0] count;

    queue_arb_ctrl #(.M_WIDTH(MW), .N_WIDTH(NW), .Q_LENGTH(QL)) dut (
        .clk(clk), .clr(clr),
        .req0(req0), .req1(req1), .data0(data0), .data1(data1),
        .gnt0(gnt0), .gnt1(gnt1),
        .q_full(qFull), .q_empty(qEmpty), .q_dout(qDout),
        .q_wr(qWr), .q_rd(qRd), .q_m_din(qMDin), .q_n_din(qNDin),
        .q_clr(qClr), .flush(flush),
        .cons_vld(consVld), .cons_data(consData), .cons_rdy(consRdy),
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int testsRun = 0;
    int failCount = 0;

    // Reference world: queue contents, consumer register and the last-served producer.
    logic [DW-1:0] fifo[$];
    int            lastM;
    logic          ovldM;
    logic [DW-1:0] oregM;
    int            expWin;
    logic          expRd;
    logic [DW-1:0] expDin;

    typedef struct {
        logic       r0;
        logic       r1;
        logic       fl;
        logic [1:0] expGnt;
    } vec_t;
    vec_t vecs[13];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        fifo.delete();
        lastM = 1;
        ovldM = 1'b0;
        oregM = '0;
    endtask

    task automatic driveEnv();
        qFull  = (fifo.size() == QL - 1);
        qEmpty = (fifo.size() == 0);
        qDout  = (fifo.size() == 0) ? '0 : fifo[0];
    endtask

    task automatic applyStimulus(input logic r0, input logic r1, input logic [DW-1:0] d0,
                                 input logic [DW-1:0] d1, input logic rdy, input logic fl);
        req0 = r0; req1 = r1; data0 = d0; data1 = d1; consRdy = rdy; flush = fl;
        driveEnv();
        #1;
    endtask

    task automatic checkModel();
        bit full, empty;
        full  = (fifo.size() == QL - 1);
        empty = (fifo.size() == 0);
        expWin = -1;
        if (!full && !flush) begin
            if (req0 && req1) expWin = (lastM + 1) % 2;
            else if (req0)    expWin = 0;
            else if (req1)    expWin = 1;
        end
        expDin = (expWin == 0) ? data0 : ((expWin == 1) ? data1 : '0);
        expRd  = !empty && !flush && (!ovldM || consRdy);
        checkOutput("gnt0", 32'(gnt0), 32'(expWin == 0));
        checkOutput("gnt1", 32'(gnt1), 32'(expWin == 1));
        checkOutput("q_wr", 32'(qWr), 32'(expWin >= 0));
        checkOutput("q_rd", 32'(qRd), 32'(expRd));
        checkOutput("q_din", 32'({qMDin, qNDin}), 32'(expDin));
        checkOutput("q_clr", 32'(qClr), 32'(!flush));
        checkOutput("count", 32'(count), 32'(fifo.size()));
        checkOutput("cons_vld", 32'(consVld), 32'(ovldM));
        if (ovldM) checkOutput("cons_data", 32'(consData), 32'(oregM));
    endtask

    task automatic advance();
        logic [DW-1:0] head;
        @(posedge clk);
        if (flush) begin
            modelReset();
            oregM = consData;
        end else begin
            head = (fifo.size() == 0) ? '0 : fifo[0];
            if (expRd) begin
                void'(fifo.pop_front());
                ovldM = 1'b1;
                oregM = head;
            end else if (ovldM && consRdy) begin
                ovldM = 1'b0;
            end
            if (expWin >= 0) begin
                fifo.push_back(expDin);
                lastM = expWin;
            end
        end
        @(negedge clk);
    endtask

    task automatic cycle(input logic r0, input logic r1, input logic rdy, input logic fl);
        applyStimulus(r0, r1, DW'($urandom), DW'($urandom), rdy, fl);
        checkModel();
        advance();
    endtask

    task automatic resetDut();
        clr = 1'b0;
        req0 = 1'b1; req1 = 1'b1; flush = 1'b0; consRdy = 1'b1;
        modelReset();
        driveEnv();
        #1;
        checkOutput("rst_gnt", 32'({gnt0, gnt1}), 32'h0);
        checkOutput("rst_strobes", 32'({qWr, qRd}), 32'h0);
        checkOutput("rst_q_clr", 32'(qClr), 32'h0);
        checkOutput("rst_count", 32'(count), 32'h0);
        checkOutput("rst_cons_vld", 32'(consVld), 32'h0);
        checkOutput("rst_cons_data", 32'(consData), 32'h0);
        @(posedge clk);
        @(negedge clk);
        clr = 1'b1;
    endtask

    initial begin
        vecs[0]  = '{1, 1, 0, 2'b10};
        vecs[1]  = '{1, 1, 0, 2'b01};
        vecs[2]  = '{1, 1, 0, 2'b10};
        vecs[3]  = '{1, 1, 0, 2'b01};
        vecs[4]  = '{0, 1, 0, 2'b01};
        vecs[5]  = '{0, 1, 0, 2'b01};
        vecs[6]  = '{0, 1, 0, 2'b01};
        vecs[7]  = '{1, 1, 0, 2'b10};
        vecs[8]  = '{0, 0, 0, 2'b00};
        vecs[9]  = '{1, 1, 0, 2'b01};
        vecs[10] = '{1, 0, 0, 2'b10};
        vecs[11] = '{1, 1, 1, 2'b00};
        vecs[12] = '{1, 1, 0, 2'b10};

        clr = 1'b0; req0 = 0; req1 = 0; data0 = '0; data1 = '0;
        flush = 0; consRdy = 0;
        modelReset();
        driveEnv();
        @(negedge clk);

        // Arbitration table: alternation, sole requester, flush restoring priority.
        resetDut();
        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].r0, vecs[i].r1, DW'($urandom), DW'($urandom), 1'b1, vecs[i].fl);
            checkModel();
            checkOutput($sformatf("tbl_gnt[%0d]", i), 32'({gnt0, gnt1}), 32'(vecs[i].expGnt));
            advance();
        end

        // Fill: one entry lands in the output register, fifteen in the queue.
        resetDut();
        for (int i = 0; i < 16; i++) cycle(1, 1, 0, 0);
        applyStimulus(1, 1, DW'($urandom), DW'($urandom), 1'b0, 1'b0);
        checkModel();
        checkOutput("full_count", 32'(count), 32'd15);
        checkOutput("full_gnt", 32'({gnt0, gnt1}), 32'h0);
        checkOutput("full_vld", 32'(consVld), 32'h1);
        advance();

        // Full queue drained by one pop: no grant that cycle, grant returns next cycle.
        applyStimulus(1, 1, DW'($urandom), DW'($urandom), 1'b1, 1'b0);
        checkModel();
        checkOutput("full_pop_rd", 32'(qRd), 32'h1);
        checkOutput("full_pop_gnt", 32'({gnt0, gnt1}), 32'h0);
        advance();
        applyStimulus(1, 1, DW'($urandom), DW'($urandom), 1'b0, 1'b0);
        checkModel();
        checkOutput("after_pop_count", 32'(count), 32'd14);
        checkOutput("after_pop_gnt", 32'(gnt0 | gnt1), 32'h1);
        advance();

        // Flush with five queued entries and a valid output register.
        resetDut();
        for (int i = 0; i < 6; i++) cycle(1, 0, 0, 0);
        applyStimulus(1, 1, DW'($urandom), DW'($urandom), 1'b1, 1'b1);
        checkModel();
        checkOutput("pre_flush_count", 32'(count), 32'd5);
        checkOutput("pre_flush_vld", 32'(consVld), 32'h1);
        checkOutput("flush_q_clr", 32'(qClr), 32'h0);
        checkOutput("flush_strobes", 32'({gnt0, gnt1, qWr, qRd}), 32'h0);
        advance();
        applyStimulus(0, 0, '0, '0, 1'b0, 1'b0);
        checkModel();
        checkOutput("post_flush_count", 32'(count), 32'd0);
        checkOutput("post_flush_vld", 32'(consVld), 32'h0);
        advance();

        // Asynchronous reset between edges while the output register holds data.
        for (int i = 0; i < 4; i++) cycle(1, 1, 0, 0);
        req0 = 1'b1; req1 = 1'b1;
        #2 clr = 1'b0;
        #1;
        checkOutput("async_rst_vld", 32'(consVld), 32'h0);
        checkOutput("async_rst_count", 32'(count), 32'h0);
        checkOutput("async_rst_data", 32'(consData), 32'h0);
        checkOutput("async_rst_gnt", 32'({gnt0, gnt1, qWr}), 32'h0);
        @(negedge clk);
        resetDut();

        // Random traffic against the reference model.
        for (int i = 0; i < 600; i++) begin
            cycle(1'($urandom), 1'($urandom), ($urandom_range(0, 9) < 6), ($urandom_range(0, 49) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule

// File: doc/queue_arb_ctrl.md
QUEUE_ARB_CTRL -- requirements
Module: queue_arb_ctrl

Interface
REQ-001 SHALL have parameter M_WIDTH, default 8, width of modifiable entry field.
REQ-002 SHALL have parameter N_WIDTH, default 8, width of fixed entry field.
REQ-003 SHALL have parameter Q_LENGTH, default 16, number of queue slots (usable capacity Q_LENGTH-1); CW = ceil(log2(Q_LENGTH)).
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port clr  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports req0, req1  input  1 each  producer write requests.
REQ-007 SHALL have ports data0, data1  input  M_WIDTH+N_WIDTH each  producer entries, M field in upper bits.
REQ-008 SHALL have ports gnt0, gnt1  output  1 each  producer grants; producer's data is taken in the cycle its grant is high.
REQ-009 SHALL have ports q_full, q_empty  input  1 each  queue status.
REQ-010 SHALL have port q_dout  input  M_WIDTH+N_WIDTH  queue head entry, combinational from queue.
REQ-011 SHALL have ports q_wr, q_rd  output  1 each  queue write and pop strobes.
REQ-012 SHALL have ports q_m_din  output  M_WIDTH and q_n_din  output  N_WIDTH  selected producer entry.
REQ-013 SHALL have port q_clr  output  1  active-low queue clear.
REQ-014 SHALL have port flush  input  1  synchronous flush request.
REQ-015 SHALL have ports cons_vld  output  1, cons_data  output  M_WIDTH+N_WIDTH, cons_rdy  input  1  consumer valid/ready handshake.
REQ-016 SHALL have port count  output  CW  number of entries held in queue (output register excluded).

Function
REQ-017 SHALL keep a 1-bit round-robin pointer last; when last=1 req0 has priority, when last=0 req1 has priority.
REQ-018 SHALL assert at most one grant per cycle, combinationally: none if q_full=1 or flush=1; otherwise the requesting producer with priority, or the sole requester.
REQ-019 SHALL update last to the granted index (0 for gnt0, 1 for gnt1) at the clock edge after a grant; no grant leaves last unchanged.
REQ-020 SHALL drive q_wr = gnt0|gnt1 and q_m_din/q_n_din from the granted producer's data; data SHALL be 0 when no grant.
REQ-021 SHALL hold an output register (valid bit ovld plus data) feeding cons_vld/cons_data directly.
REQ-022 SHALL drive q_rd = ~q_empty & ~flush & (~ovld | cons_rdy); on that edge the register loads q_dout and ovld becomes 1.
REQ-023 SHALL clear ovld on an edge where ovld & cons_rdy and no q_rd occurs.
REQ-024 SHALL treat q_full and q_empty as pre-edge status: a write is blocked when full even if a pop occurs the same cycle; a pop is not made when empty even if a write occurs the same cycle.
REQ-025 SHALL update count: +1 on q_wr only, -1 on q_rd only, unchanged on both or neither; count SHALL never wrap.
REQ-026 SHALL, on flush=1, drive q_clr=0 for that cycle, and at the edge set count=0, ovld=0, last=1; no grant or pop SHALL occur that cycle.
REQ-027 SHALL drive q_clr = 0 whenever clr=0, else ~flush.

Reset
REQ-028 SHALL, while clr=0, asynchronously force count=0, ovld=0 (cons_vld=0), cons_data=0, last=1.
REQ-029 SHALL keep gnt0, gnt1, q_wr, q_rd at 0 while clr=0 irrespective of inputs.
REQ-030 SHALL resume normal operation at the first rising edge after clr returns to 1; reset mid-transfer SHALL discard the output register contents.

Verification
REQ-031 SHALL cover: after reset, req0=req1=1 held, q_full=0 -> grants alternate gnt0,gnt1,gnt0,... each cycle.
REQ-032 SHALL cover: only req1=1 for 3 cycles -> gnt1 each cycle, then req0=req1=1 -> gnt0 next.
REQ-033 SHALL cover: Q_LENGTH=16, cons_rdy=0, continuous requests -> 1 entry to output register, then 15 queued, count=15, q_full=1, all grants 0.
REQ-034 SHALL cover: queue full and cons_rdy=1 -> q_rd=1 and no grant same cycle; count 15->14, grant resumes next cycle.
REQ-035 SHALL cover: count=5, ovld=1, flush=1 for one cycle -> q_clr=0 that cycle, next cycle count=0, cons_vld=0, no grants or pops during flush.
REQ-036 SHALL cover: clr driven 0 asynchronously between edges with ovld=1 -> cons_vld=0 and count=0 immediately, before the next clock edge.
